// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : Multi-cycle fetch/next-PC controller. Owns the program
//               counter, issues instruction fetches, latches the returned
//               instruction and loads the next PC (seq/branch/jump/jr or
//               exception vector) when the datapath finishes executing.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter logic [31:0] EXC_VEC  = 32'h0040_0004
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        run,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ir,
  output logic        ir_valid,
  input  logic        exec_done,
  input  logic [1:0]  npc_sel,
  input  logic        branch_taken,
  input  logic [15:0] br_offset,
  input  logic [25:0] jmp_target,
  input  logic [31:0] jr_addr,
  input  logic        exc_req,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] epc,
  output logic        exc_taken,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic [31:0] r_epc;
  logic        r_exc_taken;

  logic        w_fetch_hit;   // instruction accepted this cycle
  logic        w_retire;      // current instruction finishes this cycle
  logic        w_exc;         // retiring instruction raises an exception
  logic [31:0] w_pc_plus4;
  logic [31:0] w_br_disp;
  logic [31:0] w_npc;

  // Next-state decode; inputs outside their owning state are ignored
  always_comb begin
    w_state_nxt = r_state;
    w_fetch_hit = 1'b0;
    w_retire    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (run) w_state_nxt = ST_FETCH;
      end
      ST_FETCH: begin
        if (imem_ack) begin
          w_fetch_hit = 1'b1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        if (exec_done) begin
          w_retire    = 1'b1;
          w_state_nxt = ST_FETCH;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Next-PC selection; a misaligned jr target is diverted to the exception vector
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_br_disp  = {{14{br_offset[15]}}, br_offset, 2'b00};
    w_npc      = w_pc_plus4;
    case (npc_sel)
      2'd1:    w_npc = branch_taken ? (w_pc_plus4 + w_br_disp) : w_pc_plus4;
      2'd2:    w_npc = {w_pc_plus4[31:28], jmp_target, 2'b00};
      2'd3:    w_npc = jr_addr;
      default: w_npc = w_pc_plus4;
    endcase
    w_exc = exc_req || ((npc_sel == 2'd3) && (jr_addr[1:0] != 2'b00));
  end

  // Architectural state; reset overrides every other input
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_pc        <= RESET_PC;
      r_ir        <= 32'd0;
      r_ir_valid  <= 1'b0;
      r_epc       <= 32'd0;
      r_exc_taken <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ir_valid  <= w_fetch_hit;
      r_exc_taken <= w_retire && w_exc;
      if (w_fetch_hit) r_ir <= imem_rdata;
      if (w_retire) begin
        if (w_exc) begin
          r_pc  <= EXC_VEC;
          r_epc <= r_pc;
        end else begin
          r_pc  <= w_npc;
        end
      end
    end
  end

  assign imem_req  = (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign ir        = r_ir;
  assign ir_valid  = r_ir_valid;
  assign pc        = r_pc;
  assign pc_plus4  = w_pc_plus4;
  assign epc       = r_epc;
  assign exc_taken = r_exc_taken;
  assign state     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer. A behavioural model
//               tracks the expected PC/IR/EPC per cycle; directed scenarios
//               pin the model with literal values, then random traffic runs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  localparam logic [31:0] C_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] C_EXC_VEC  = 32'h0040_0004;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'd0;
  logic [31:0] ir;
  logic        ir_valid;
  logic        exec_done = 1'b0;
  logic [1:0]  npc_sel = 2'd0;
  logic        branch_taken = 1'b0;
  logic [15:0] br_offset = 16'd0;
  logic [25:0] jmp_target = 26'd0;
  logic [31:0] jr_addr = 32'd0;
  logic        exc_req = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic [31:0] epc;
  logic        exc_taken;
  logic [1:0]  state;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  pc_sequencer #(.RESET_PC(C_RESET_PC), .EXC_VEC(C_EXC_VEC)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
    .imem_rdata(imem_rdata), .ir(ir), .ir_valid(ir_valid),
    .exec_done(exec_done), .npc_sel(npc_sel), .branch_taken(branch_taken),
    .br_offset(br_offset), .jmp_target(jmp_target), .jr_addr(jr_addr),
    .exc_req(exc_req), .pc(pc), .pc_plus4(pc_plus4), .epc(epc),
    .exc_taken(exc_taken), .state(state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got 0x%08h expected 0x%08h", name, $time, act, exp);
    end
  endtask

  // Behavioural model: 0 idle, 1 fetching, 2 executing
  int          m_state;
  logic [31:0] m_pc, m_ir, m_epc;
  bit          m_irv, m_exc;

  always @(posedge clk) begin
    logic [31:0] seq, tgt;
    logic signed [31:0] sx;
    if (rst) begin
      m_state = 0; m_pc = C_RESET_PC; m_ir = 0; m_irv = 0; m_epc = 0; m_exc = 0;
    end else begin
      m_irv = 0;
      m_exc = 0;
      if (m_state == 0) begin
        if (run) m_state = 1;
      end else if (m_state == 1) begin
        if (imem_ack) begin
          m_ir = imem_rdata; m_irv = 1; m_state = 2;
        end
      end else if (exec_done) begin
        seq = m_pc + 32'd4;
        sx  = $signed(br_offset);
        case (npc_sel)
          2'd1:    tgt = branch_taken ? seq + 32'(sx * 4) : seq;
          2'd2:    tgt = (seq & 32'hF000_0000) | (32'(jmp_target) * 32'd4);
          2'd3:    tgt = jr_addr;
          default: tgt = seq;
        endcase
        if (exc_req || (npc_sel == 2'd3 && (jr_addr % 4) != 0)) begin
          m_epc = m_pc; m_pc = C_EXC_VEC; m_exc = 1;
        end else begin
          m_pc = tgt;
        end
        m_state = 1;
      end
    end
  end

  // Compare process: every output against the model, away from the edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("state",     32'(state),     32'(m_state));
      chk("pc",        pc,             m_pc);
      chk("pc_plus4",  pc_plus4,       m_pc + 32'd4);
      chk("imem_req",  32'(imem_req),  32'(m_state == 1));
      chk("imem_addr", imem_addr,      m_pc);
      chk("ir",        ir,             m_ir);
      chk("ir_valid",  32'(ir_valid),  32'(m_irv));
      chk("epc",       epc,            m_epc);
      chk("exc_taken", 32'(exc_taken), 32'(m_exc));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic junk_exec();
    exec_done    = 1'($urandom);
    exc_req      = 1'($urandom);
    npc_sel      = 2'($urandom);
    branch_taken = 1'($urandom);
    br_offset    = 16'($urandom);
    jmp_target   = 26'($urandom);
    jr_addr      = $urandom;
  endtask

  task automatic fetch(input int w, input logic [31:0] instr);
    repeat (w) begin
      imem_ack = 1'b0; imem_rdata = $urandom; junk_exec(); cyc();
    end
    imem_ack = 1'b1; imem_rdata = instr; junk_exec(); cyc();
    imem_ack = 1'b0;
  endtask

  task automatic exec(input int w, input logic [1:0] sel, input logic tk,
                      input logic [15:0] off, input logic [25:0] tgt,
                      input logic [31:0] jr, input logic exc);
    repeat (w) begin
      junk_exec(); exec_done = 1'b0;
      imem_ack = 1'($urandom); imem_rdata = $urandom; cyc();
    end
    exec_done = 1'b1; npc_sel = sel; branch_taken = tk; br_offset = off;
    jmp_target = tgt; jr_addr = jr; exc_req = exc;
    imem_ack = 1'($urandom); imem_rdata = $urandom;
    cyc();
    exec_done = 1'b0; exc_req = 1'b0; imem_ack = 1'b0;
  endtask

  task automatic goto_pc(input logic [31:0] a);
    fetch(0, $urandom | 32'd1);
    exec(0, 2'd3, 1'b0, 16'd0, 26'd0, a, 1'b0);
  endtask

  int req_cnt;

  initial begin
    // Reset and start
    rst = 1'b1; cyc(); chk_en = 1'b1; cyc();
    rst = 1'b0;
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_pc", pc, 32'h0040_0000);
    chk("rst_ir", ir, 32'd0);
    chk("rst_req", 32'(imem_req), 32'd0);
    cyc();
    chk("idle_hold", 32'(state), 32'd0);
    run = 1'b1; cyc(); run = 1'b0;
    chk("start_addr", imem_addr, 32'h0040_0000);
    chk("start_req", 32'(imem_req), 32'd1);
    fetch(0, 32'hDEAD_BEEF);
    chk("first_irv", 32'(ir_valid), 32'd1);
    chk("first_ir", ir, 32'hDEAD_BEEF);
    exec(0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
    chk("seq_pc", pc, 32'h0040_0004);

    // Wait states: request held for 4 cycles at a constant address
    req_cnt = 0;
    repeat (3) begin
      imem_ack = 1'b0; cyc();
      if (imem_req && imem_addr == 32'h0040_0004) req_cnt++;
    end
    imem_ack = 1'b1; imem_rdata = 32'h1111_2222; cyc(); imem_ack = 1'b0;
    chk("wait_req_cycles", 32'(req_cnt + 1), 32'd4);
    chk("wait_ir", ir, 32'h1111_2222);
    exec(2, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0040_0010, 1'b0);
    chk("jr_pc10", pc, 32'h0040_0010);

    // Branch taken / not taken
    fetch(1, 32'h1000_FFFC);
    exec(0, 2'd1, 1'b1, 16'hFFFC, 26'd0, 32'd0, 1'b0);
    chk("br_taken", pc, 32'h0040_0004);
    goto_pc(32'h0040_0010);
    fetch(0, 32'h1000_FFFC);
    exec(1, 2'd1, 1'b0, 16'hFFFC, 26'd0, 32'd0, 1'b0);
    chk("br_not_taken", pc, 32'h0040_0014);

    // Jump, jr and wrap
    goto_pc(32'h0040_0020);
    fetch(0, 32'h0810_0008);
    exec(0, 2'd2, 1'b0, 16'd0, 26'h010_0008, 32'd0, 1'b0);
    chk("jump", pc, 32'h0040_0020);
    goto_pc(32'h0040_0100);
    chk("jr", pc, 32'h0040_0100);
    goto_pc(32'hFFFF_FFFC);
    fetch(0, 32'd0);
    exec(0, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b0);
    chk("wrap", pc, 32'h0000_0000);

    // Exceptions
    goto_pc(32'h0040_0030);
    fetch(0, 32'h0000_000C);
    exec(1, 2'd0, 1'b0, 16'd0, 26'd0, 32'd0, 1'b1);
    chk("exc_pc", pc, 32'h0040_0004);
    chk("exc_epc", epc, 32'h0040_0030);
    chk("exc_pulse", 32'(exc_taken), 32'd1);
    chk("exc_state", 32'(state), 32'd1);
    imem_ack = 1'b0; cyc();
    chk("exc_pulse_end", 32'(exc_taken), 32'd0);
    goto_pc(32'h0040_0200);
    fetch(0, 32'h0000_0008);
    exec(0, 2'd3, 1'b0, 16'd0, 26'd0, 32'h0040_0102, 1'b0);
    chk("jr_misalign_pc", pc, 32'h0040_0004);
    chk("jr_misalign_epc", epc, 32'h0040_0200);
    chk("jr_misalign_pulse", 32'(exc_taken), 32'd1);

    // Reset mid-FETCH with ack present
    imem_ack = 1'b1; imem_rdata = 32'h1234_5678; rst = 1'b1; cyc();
    rst = 1'b0; imem_ack = 1'b0;
    chk("rstF_state", 32'(state), 32'd0);
    chk("rstF_pc", pc, 32'h0040_0000);
    chk("rstF_ir", ir, 32'd0);
    chk("rstF_epc", epc, 32'd0);

    // Reset mid-EXEC with exec_done present
    run = 1'b1; cyc(); run = 1'b0;
    fetch(0, 32'hCAFE_F00D);
    exec_done = 1'b1; npc_sel = 2'd3; jr_addr = 32'h0040_0200; rst = 1'b1; cyc();
    rst = 1'b0; exec_done = 1'b0;
    chk("rstE_state", 32'(state), 32'd0);
    chk("rstE_pc", pc, 32'h0040_0000);
    chk("rstE_ir", ir, 32'd0);

    // Random traffic
    run = 1'b1; cyc(); run = 1'b0;
    for (int i = 0; i < 400; i++) begin
      logic [31:0] jr;
      if ($urandom_range(0, 39) == 0) begin
        rst = 1'b1; imem_ack = 1'($urandom); exec_done = 1'($urandom); cyc();
        rst = 1'b0; imem_ack = 1'b0; exec_done = 1'b0;
        repeat ($urandom_range(0, 2)) begin run = 1'b0; imem_ack = 1'($urandom); cyc(); end
        run = 1'b1; cyc(); run = 1'b0;
      end
      fetch($urandom_range(0, 3), $urandom);
      jr = $urandom;
      if ($urandom_range(0, 3) != 0) jr[1:0] = 2'b00;
      exec($urandom_range(0, 3), 2'($urandom), 1'($urandom), 16'($urandom),
           26'($urandom), jr, 1'($urandom_range(0, 7) == 0));
    end

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pc_sequencer.md
# pc_sequencer

Multi-cycle fetch/next-PC controller for the 31-instruction MIPS CPU. Owns the program counter and sequences IDLE → FETCH → EXEC. It issues instruction-memory requests from the current PC, latches the returned instruction, and waits for the datapath to finish executing it. It then loads the next PC from the sequential, branch, jump, jump-register or exception source.

## Interface
- RESET_PC, 32'h00400000, PC value after reset (instruction memory base)
- EXC_VEC, 32'h00400004, PC loaded on any exception

- clk  in  1  system clock; all state changes on rising edge
- rst  in  1  synchronous, active-high reset
- run  in  1  leave IDLE and start fetching
- imem_req  out  1  fetch request; high in every FETCH cycle
- imem_addr  out  32  fetch address; equals pc
- imem_ack  in  1  instruction memory has valid data this cycle
- imem_rdata  in  32  instruction word, valid when imem_ack=1
- ir  out  32  latched instruction register
- ir_valid  out  1  one-cycle pulse: ir holds a new instruction
- exec_done  in  1  datapath finished current instruction; next-PC inputs valid
- npc_sel  in  2  0 sequential, 1 branch, 2 jump, 3 jump-register
- branch_taken  in  1  branch condition result (used when npc_sel=1)
- br_offset  in  16  branch immediate
- jmp_target  in  26  jump index field
- jr_addr  in  32  register value for jump-register
- exc_req  in  1  datapath exception (overflow, syscall, break)
- pc  out  32  current PC
- pc_plus4  out  32  pc + 4, combinational
- epc  out  32  PC of the last excepting instruction
- exc_taken  out  1  one-cycle pulse when exception vector is loaded
- state  out  2  0 IDLE, 1 FETCH, 2 EXEC (debug)

## Operation
- IDLE: imem_req=0. Go to FETCH when run=1; otherwise stay.
- FETCH: imem_req=1, imem_addr=pc. The request is held until imem_ack.
  - On imem_ack: ir<=imem_rdata, then go to EXEC.
  - Without ack: stay in FETCH, pc and ir unchanged.
- EXEC: wait for exec_done. On exec_done, pc<=npc and state goes back to FETCH. The run input is not re-checked.
- npc computation (all mod 2^32, wrap silently):
  - seq = pc+4
  - branch = pc+4 + (sign_extend(br_offset) << 2)
  - jump = {pc_plus4[31:28], jmp_target, 2'b00}
  - jr = jr_addr
  - npc_sel=1 with branch_taken=0 yields seq.
- Exception priority, evaluated only on exec_done:
  - Trigger: exc_req=1, or npc_sel=3 with jr_addr[1:0]≠0.
  - Action: pc<=EXC_VEC, epc<=pc, exc_taken=1 for one cycle. This overrides npc_sel.
- Inputs are ignored outside their states: exc_req, exec_done and next-PC inputs outside EXEC; imem_ack outside FETCH.
- Only the jr target is alignment-checked. A misaligned jr_addr never reaches pc.

## Timing
- Reset (rst=1 at an edge), from any state, including mid-FETCH with ack present:
  - state=IDLE, pc=RESET_PC, ir=0, ir_valid=0, epc=0, exc_taken=0, imem_req=0.
  - Reset beats every other input.
- imem_req and imem_addr are combinational from state/pc. ir, ir_valid, pc, epc, exc_taken and state are registered.
- ir_valid is high exactly in the first EXEC cycle after the ack edge.
- Minimum instruction period is 2 cycles: FETCH with immediate ack, then EXEC with exec_done in its first cycle.
- A zero-wait fetch issues its request 1 cycle after the exec_done edge.
- If exec_done is asserted in the ir_valid cycle, it is honored.
- exc_taken is high in the cycle after the exec_done edge. In that same cycle state=FETCH and pc=EXC_VEC.

## Test plan
- Reset and start: rst 1 cycle, run=1, ack immediately → pc=0x00400000, imem_addr=0x00400000; ir_valid pulses 1 cycle later with ir=imem_rdata.
- Sequential and wait states: ack delayed 3 cycles → imem_req high 4 cycles with a constant address. exec_done with npc_sel=0 → next fetch at 0x00400004.
- Branch: pc=0x00400010, npc_sel=1, taken, br_offset=16'hFFFC → pc=0x00400004. Same stimulus with taken=0 → pc=0x00400014.
- Jump and jr: pc=0x00400020, jmp_target=26'h0100008 → pc=0x00400020. jr_addr=0x00400100 → pc=0x00400100. Wrap case: pc=0xFFFFFFFC, sequential → pc=0x00000000.
- Exceptions: exc_req with exec_done at pc=0x00400030 → pc=0x00400004, epc=0x00400030, one exc_taken pulse. jr_addr=0x00400102 → same vector path.
- Reset mid-operation: assert rst in FETCH while imem_ack=1, and separately in EXEC with exec_done=1 → ir and pc are not updated; state=IDLE and pc=RESET_PC next cycle.
